// File: rtl/eth_type_pkg.sv
// eth_type_pkg
// Shared EtherType constants (also used by the TX ARP/IP merge stage),
// the receive dispatcher FSM state encodings and the EtherType decode helper.
package eth_type_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FWD_A = 2'd1;
    localparam logic [1:0] ST_FWD_B = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    // Map an EtherType to the state that owns the frame
    function automatic logic [1:0] decode_type(input logic [15:0] eth_type);
        logic [1:0] st;
        st = ST_DROP;
        if (eth_type == ETH_TYPE_ARP) begin
            st = ST_FWD_A;
        end else if (eth_type == ETH_TYPE_IP) begin
            st = ST_FWD_B;
        end
        return st;
    endfunction

endpackage

// File: rtl/data_1to2_dispatcher.sv
// data_1to2_dispatcher
// Steers whole byte-wide RX frames to the ARP port (A) or the IP port (B)
// by EtherType; other EtherTypes are discarded and counted.
// Optional build macro LEN_CHECK_EN enables the frame length check
// (forced last on long frames, o_len_err pulse on long/short/aborted frames).
module data_1to2_dispatcher
    import eth_type_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_last,
    input  logic [15:0] i_len,
    input  logic [15:0] i_type,
    output logic [7:0]  o_data_a,
    output logic        o_valid_a,
    output logic        o_last_a,
    output logic [15:0] o_len_a,
    output logic [15:0] o_type_a,
    output logic [7:0]  o_data_b,
    output logic        o_valid_b,
    output logic        o_last_b,
    output logic [15:0] o_len_b,
    output logic [15:0] o_type_b,
    output logic [15:0] o_drop_cnt,
    output logic        o_len_err
);

    logic [7:0]  ri_data;
    logic        ri_valid;
    logic        ri_last;
    logic [15:0] ri_len;
    logic [15:0] ri_type;
    logic        ri_valid_1d;
    logic        ri_last_1d;
    logic        loaded;
    logic        skip;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [1:0]  route;
    logic        start;
    logic        last_out;
    logic        sel_a;
    logic        sel_b;

`ifdef LEN_CHECK_EN
    logic [15:0] beat_cnt;
    logic [15:0] beat_num;
    logic [15:0] cur_len;
    logic [15:0] frame_len;
    logic        len_err_c;
`endif

    // Input register stage; skip hides the tail of a frame cut by reset.
    // A frame whose first beat is sampled on the very first clock after
    // reset release cannot be told apart from such a tail and is ignored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ri_data     <= '0;
            ri_valid    <= 1'b0;
            ri_last     <= 1'b0;
            ri_len      <= '0;
            ri_type     <= '0;
            ri_valid_1d <= 1'b0;
            ri_last_1d  <= 1'b0;
            loaded      <= 1'b0;
            skip        <= 1'b1;
        end else begin
            ri_data     <= i_data;
            ri_valid    <= i_valid;
            ri_last     <= i_last;
            ri_len      <= i_len;
            ri_type     <= i_type;
            ri_valid_1d <= ri_valid;
            ri_last_1d  <= ri_last;
            loaded      <= 1'b1;
            if (loaded && (!ri_valid || ri_last)) begin
                skip <= 1'b0;
            end
        end
    end

    assign start = ri_valid && !skip && (!ri_valid_1d || ri_last_1d);
    assign sel_a = ri_valid && (route == ST_FWD_A);
    assign sel_b = ri_valid && (route == ST_FWD_B);

    // Route the current beat, compute the next FSM state and the length check
    always_comb begin
        route      = ST_IDLE;
        next_state = ST_IDLE;
        last_out   = 1'b0;
`ifdef LEN_CHECK_EN
        frame_len  = cur_len;
        beat_num   = '0;
        len_err_c  = 1'b0;
`endif
        if (ri_valid) begin
            if (start) begin
                route = decode_type(ri_type);
`ifdef LEN_CHECK_EN
                frame_len = ri_len;
`endif
            end else begin
                route = state;
            end
            next_state = ri_last ? ST_IDLE : route;
            last_out   = ri_last;
        end
`ifdef LEN_CHECK_EN
        if (ri_valid && (route == ST_FWD_A || route == ST_FWD_B)) begin
            beat_num = start ? 16'd1 : beat_cnt + 16'd1;
            if (frame_len != 16'd0) begin
                if (!ri_last && (beat_num == frame_len)) begin
                    last_out   = 1'b1;
                    len_err_c  = 1'b1;
                    next_state = ST_DROP;
                end else if (ri_last && (beat_num < frame_len)) begin
                    len_err_c = 1'b1;
                end
            end
        end
        if (!ri_valid && (state == ST_FWD_A || state == ST_FWD_B)) begin
            len_err_c = 1'b1;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

`ifdef LEN_CHECK_EN
    // Beat counter and latched frame length for the length check
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat_cnt  <= '0;
            cur_len   <= '0;
            o_len_err <= 1'b0;
        end else begin
            beat_cnt  <= beat_num;
            cur_len   <= frame_len;
            o_len_err <= len_err_c;
        end
    end
`else
    assign o_len_err = 1'b0;
`endif

    // Registered output ports; the unselected port is held at zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data_a  <= '0;
            o_valid_a <= 1'b0;
            o_last_a  <= 1'b0;
            o_len_a   <= '0;
            o_type_a  <= '0;
            o_data_b  <= '0;
            o_valid_b <= 1'b0;
            o_last_b  <= 1'b0;
            o_len_b   <= '0;
            o_type_b  <= '0;
        end else begin
            o_valid_a <= sel_a;
            o_data_a  <= sel_a ? ri_data : 8'd0;
            o_last_a  <= sel_a && last_out;
            o_valid_b <= sel_b;
            o_data_b  <= sel_b ? ri_data : 8'd0;
            o_last_b  <= sel_b && last_out;
            if (start && sel_a) begin
                o_len_a  <= ri_len;
                o_type_a <= ri_type;
            end
            if (start && sel_b) begin
                o_len_b  <= ri_len;
                o_type_b <= ri_type;
            end
        end
    end

    // Saturating count of frames discarded for an unknown EtherType
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_drop_cnt <= '0;
        end else if (start && (route == ST_DROP) && (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_data_1to2_dispatcher.sv
// tb_data_1to2_dispatcher
// Directed bench for data_1to2_dispatcher; build with or without LEN_CHECK_EN.
module tb_data_1to2_dispatcher;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_last;
    logic [15:0] i_len;
    logic [15:0] i_type;
    logic [7:0]  o_data_a;
    logic        o_valid_a;
    logic        o_last_a;
    logic [15:0] o_len_a;
    logic [15:0] o_type_a;
    logic [7:0]  o_data_b;
    logic        o_valid_b;
    logic        o_last_b;
    logic [15:0] o_len_b;
    logic [15:0] o_type_b;
    logic [15:0] o_drop_cnt;
    logic        o_len_err;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int in_cyc;
    int cnt_a, cnt_b, lastcnt_a, lastcnt_b, lastpos_a, lastpos_b;
    int first_a, first_b, end_a, end_b;
    int lenerr_cnt, lenerr_last, idle_bad;
    logic [15:0] len_a_seen, type_a_seen, len_b_seen, type_b_seen;
    logic [7:0]  data_a_first, data_a_last, data_b_first, data_b_last;

    data_1to2_dispatcher dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_last     (i_last),
        .i_len      (i_len),
        .i_type     (i_type),
        .o_data_a   (o_data_a),
        .o_valid_a  (o_valid_a),
        .o_last_a   (o_last_a),
        .o_len_a    (o_len_a),
        .o_type_a   (o_type_a),
        .o_data_b   (o_data_b),
        .o_valid_b  (o_valid_b),
        .o_last_b   (o_last_b),
        .o_len_b    (o_len_b),
        .o_type_b   (o_type_b),
        .o_drop_cnt (o_drop_cnt),
        .o_len_err  (o_len_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task clearMonitor();
        cnt_a = 0; cnt_b = 0; lastcnt_a = 0; lastcnt_b = 0;
        lastpos_a = 0; lastpos_b = 0; first_a = -1; first_b = -1;
        end_a = -1; end_b = -1; lenerr_cnt = 0; lenerr_last = 0;
        len_a_seen = '0; type_a_seen = '0; len_b_seen = '0; type_b_seen = '0;
        data_a_first = '0; data_a_last = '0; data_b_first = '0; data_b_last = '0;
    endtask

    task idleCycles(input int n);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = 8'd0;
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    // One frame of nbeats contiguous beats; data byte k is seed + k
    task applyStimulus(input logic [15:0] etype, input logic [15:0] len, input int nbeats,
                       input bit with_last, input logic [7:0] seed);
        in_cyc = cyc;
        for (int b = 1; b <= nbeats; b++) begin
            i_valid = 1'b1;
            i_data  = seed + 8'(b);
            i_last  = with_last && (b == nbeats);
            i_len   = len;
            i_type  = etype;
            @(posedge i_clk); #1;
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge i_clk) begin
        cyc++;
        if (o_valid_a) begin
            cnt_a++;
            if (cnt_a == 1) begin
                first_a = cyc; len_a_seen = o_len_a; type_a_seen = o_type_a; data_a_first = o_data_a;
            end
            end_a = cyc; data_a_last = o_data_a;
            if (o_last_a) begin lastcnt_a++; lastpos_a = cnt_a; end
        end else if (o_data_a != 8'd0 || o_last_a) begin
            idle_bad++;
        end
        if (o_valid_b) begin
            cnt_b++;
            if (cnt_b == 1) begin
                first_b = cyc; len_b_seen = o_len_b; type_b_seen = o_type_b; data_b_first = o_data_b;
            end
            end_b = cyc; data_b_last = o_data_b;
            if (o_last_b) begin lastcnt_b++; lastpos_b = cnt_b; end
        end else if (o_data_b != 8'd0 || o_last_b) begin
            idle_bad++;
        end
        if (o_len_err) begin
            lenerr_cnt++;
            if (o_last_a || o_last_b) lenerr_last++;
        end
    end

    initial begin
        idle_bad = 0;
        clearMonitor();
        i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = '0; i_len = '0; i_type = '0;
        repeat (3) begin @(posedge i_clk); #1; end

        // Reset state
        checkOutput("rst_valid_a", 32'(o_valid_a), 32'd0);
        checkOutput("rst_valid_b", 32'(o_valid_b), 32'd0);
        checkOutput("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
        checkOutput("rst_len_err", 32'(o_len_err), 32'd0);
        checkOutput("rst_len_a", 32'(o_len_a), 32'd0);
        checkOutput("rst_type_b", 32'(o_type_b), 32'd0);
        i_rst = 1'b0;
        idleCycles(3);

        // ARP frame, 28 beats
        clearMonitor();
        applyStimulus(16'h0806, 16'd28, 28, 1'b1, 8'h10);
        idleCycles(5);
        checkOutput("arp_cnt_a", cnt_a, 28);
        checkOutput("arp_lastcnt_a", lastcnt_a, 1);
        checkOutput("arp_lastpos_a", lastpos_a, 28);
        checkOutput("arp_cnt_b", cnt_b, 0);
        checkOutput("arp_len_a", 32'(len_a_seen), 32'd28);
        checkOutput("arp_type_a", 32'(type_a_seen), 32'h0806);
        checkOutput("arp_data_first", 32'(data_a_first), 32'h11);
        checkOutput("arp_data_last", 32'(data_a_last), 32'h2C);
        // two clocks of latency plus the half-cycle to the sampling edge
        checkOutput("arp_latency", first_a - in_cyc, 3);
        checkOutput("arp_len_err", lenerr_cnt, 0);

        // IP 60 then ARP 28 back to back
        clearMonitor();
        applyStimulus(16'h0800, 16'd60, 60, 1'b1, 8'h40);
        applyStimulus(16'h0806, 16'd28, 28, 1'b1, 8'h80);
        idleCycles(5);
        checkOutput("b2b_cnt_b", cnt_b, 60);
        checkOutput("b2b_cnt_a", cnt_a, 28);
        checkOutput("b2b_lastcnt_b", lastcnt_b, 1);
        checkOutput("b2b_lastcnt_a", lastcnt_a, 1);
        checkOutput("b2b_no_bubble", first_a, end_b + 1);
        checkOutput("b2b_len_b", 32'(len_b_seen), 32'd60);
        checkOutput("b2b_type_b", 32'(type_b_seen), 32'h0800);
        checkOutput("b2b_len_a", 32'(len_a_seen), 32'd28);
        checkOutput("b2b_data_b_last", 32'(data_b_last), 32'h7C);
        checkOutput("b2b_data_a_first", 32'(data_a_first), 32'h81);
        checkOutput("b2b_len_b_hold", 32'(o_len_b), 32'd60);

        // Unknown EtherType is dropped and counted
        checkOutput("drop_cnt_before", 32'(o_drop_cnt), 32'd0);
        clearMonitor();
        applyStimulus(16'h86DD, 16'd40, 40, 1'b1, 8'h00);
        idleCycles(5);
        checkOutput("drop_cnt_a", cnt_a, 0);
        checkOutput("drop_cnt_b", cnt_b, 0);
        checkOutput("drop_cnt_one", 32'(o_drop_cnt), 32'd1);
        checkOutput("drop_len_a_hold", 32'(o_len_a), 32'd28);

        // Saturation with single-beat back-to-back frames
        for (int k = 0; k < 65533; k++) applyStimulus(16'h86DD, 16'd1, 1, 1'b1, 8'h00);
        idleCycles(4);
        checkOutput("drop_cnt_fffe", 32'(o_drop_cnt), 32'hFFFE);
        applyStimulus(16'h86DD, 16'd1, 1, 1'b1, 8'h00);
        idleCycles(4);
        checkOutput("drop_cnt_ffff", 32'(o_drop_cnt), 32'hFFFF);
        applyStimulus(16'h86DD, 16'd1, 1, 1'b1, 8'h00);
        applyStimulus(16'h86DD, 16'd1, 1, 1'b1, 8'h00);
        idleCycles(4);
        checkOutput("drop_cnt_sat", 32'(o_drop_cnt), 32'hFFFF);
        checkOutput("drop_sat_cnt_a", cnt_a, 0);

        // Reset at beat 10 of a 60-beat IP frame
        clearMonitor();
        for (int b = 1; b <= 9; b++) begin
            i_valid = 1'b1; i_data = 8'h20 + 8'(b); i_last = 1'b0; i_len = 16'd60; i_type = 16'h0800;
            @(posedge i_clk); #1;
        end
        i_data = 8'h2A;
        checkOutput("rstmid_cnt_b_pre", cnt_b, 7);
        checkOutput("rstmid_valid_b_pre", 32'(o_valid_b), 32'd1);
        i_rst = 1'b1;
        #1;
        checkOutput("rstmid_valid_b", 32'(o_valid_b), 32'd0);
        checkOutput("rstmid_data_b", 32'(o_data_b), 32'd0);
        checkOutput("rstmid_len_b", 32'(o_len_b), 32'd0);
        checkOutput("rstmid_drop_cnt", 32'(o_drop_cnt), 32'd0);
        clearMonitor();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int b = 11; b <= 60; b++) begin
            i_valid = 1'b1; i_data = 8'h20 + 8'(b); i_last = (b == 60);
            @(posedge i_clk); #1;
        end
        idleCycles(5);
        checkOutput("rstmid_tail_b", cnt_b, 0);
        checkOutput("rstmid_tail_a", cnt_a, 0);
        clearMonitor();
        applyStimulus(16'h0806, 16'd28, 28, 1'b1, 8'h30);
        idleCycles(5);
        checkOutput("rstmid_next_a", cnt_a, 28);
        checkOutput("rstmid_next_last", lastcnt_a, 1);
        checkOutput("rstmid_next_len", 32'(len_a_seen), 32'd28);

        // Abort: valid falls after beat 8 with no last
        clearMonitor();
        applyStimulus(16'h0806, 16'd28, 8, 1'b0, 8'h50);
        idleCycles(5);
        checkOutput("abort_cnt_a", cnt_a, 8);
        checkOutput("abort_lastcnt_a", lastcnt_a, 0);
`ifdef LEN_CHECK_EN
        checkOutput("abort_len_err", lenerr_cnt, 1);
`else
        checkOutput("abort_len_err", lenerr_cnt, 0);
`endif
        checkOutput("abort_len_err_last", lenerr_last, 0);
        clearMonitor();
        applyStimulus(16'h0800, 16'd4, 4, 1'b1, 8'h60);
        idleCycles(5);
        checkOutput("abort_next_b", cnt_b, 4);
        checkOutput("abort_next_a", cnt_a, 0);
        checkOutput("abort_next_lastpos", lastpos_b, 4);

        // Long frame: len 20, 25 beats
        clearMonitor();
        applyStimulus(16'h0800, 16'd20, 25, 1'b1, 8'h00);
        idleCycles(5);
`ifdef LEN_CHECK_EN
        checkOutput("long_cnt_b", cnt_b, 20);
        checkOutput("long_lastpos_b", lastpos_b, 20);
        checkOutput("long_len_err", lenerr_cnt, 1);
        checkOutput("long_len_err_last", lenerr_last, 1);
`else
        checkOutput("long_cnt_b", cnt_b, 25);
        checkOutput("long_lastpos_b", lastpos_b, 25);
        checkOutput("long_len_err", lenerr_cnt, 0);
`endif
        checkOutput("long_lastcnt_b", lastcnt_b, 1);
        checkOutput("long_drop_cnt", 32'(o_drop_cnt), 32'd0);

        // Short frame: len 20, last on beat 15
        clearMonitor();
        applyStimulus(16'h0800, 16'd20, 15, 1'b1, 8'h00);
        idleCycles(5);
        checkOutput("short_cnt_b", cnt_b, 15);
        checkOutput("short_lastpos_b", lastpos_b, 15);
`ifdef LEN_CHECK_EN
        checkOutput("short_len_err_last", lenerr_last, 1);
        checkOutput("short_len_err", lenerr_cnt, 1);
`else
        checkOutput("short_len_err", lenerr_cnt, 0);
`endif

        checkOutput("idle_port_quiet", idle_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
